icache_refill_axi: RTL and testbench

//  Memory-side responder of the icache_mem refill interface; the ICache is the master.

---
 rtl/pipeline_types_pkg.sv | 17 +
 rtl/icache_refill_axi.sv | 115 +++++++++++
 tb/tb_icache_refill_axi.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_types_pkg.sv
// Shared bus and state types for the fetch/refill path.
package pipeline_types;

    typedef logic [31:0]  bus32_t;
    typedef logic [255:0] bus256_t;

    localparam int          ICACHE_LINE_BITS = 256;
    localparam logic [1:0]  AXI_BURST_INCR   = 2'b01;

    typedef enum logic [1:0] {
        REFILL_IDLE,
        REFILL_AR,
        REFILL_R,
        REFILL_DONE
    } refill_state_t;

endpackage

// File: rtl/icache_refill_axi.sv
// ICache line refill responder: one AXI4 INCR burst per request, beats
// packed into a full line and returned with a one-cycle ret_valid pulse.
//
// state        | meaning
// -------------+------------------------------------------------------
// REFILL_IDLE  | waiting for rd_req; the only state that accepts one
// REFILL_AR    | arvalid high, waiting for arready
// REFILL_R     | rready high, storing beats until beat BEATS-1
// REFILL_DONE  | ret_valid/bus_err high for this single cycle
module icache_refill_axi
    import pipeline_types::*;
#(
    parameter int         AXI_DW    = 32,
    parameter int         LINE_BITS = ICACHE_LINE_BITS,
    parameter logic [3:0] AXI_ID    = 4'd0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd_req,
    input  bus32_t               rd_addr,
    output logic                 ret_valid,
    output logic [LINE_BITS-1:0] ret_data,
    output logic                 bus_err,
    output logic [3:0]           arid,
    output logic [31:0]          araddr,
    output logic [7:0]           arlen,
    output logic [2:0]           arsize,
    output logic [1:0]           arburst,
    output logic                 arvalid,
    input  logic                 arready,
    input  logic [AXI_DW-1:0]    rdata,
    input  logic [1:0]           rresp,
    input  logic                 rlast,
    input  logic                 rvalid,
    output logic                 rready
);

    localparam int BEATS = LINE_BITS / AXI_DW;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    refill_state_t    state;
    logic [CNT_W-1:0] beat_cnt;
    logic             err_flag;
    logic             beat_err;
    logic             unused_inputs;

    assign arid    = AXI_ID;
    assign arlen   = 8'(BEATS - 1);
    assign arsize  = 3'($clog2(AXI_DW / 8));
    assign arburst = AXI_BURST_INCR;

    assign beat_err = (rresp != 2'b00);

    // Burst length is fixed, so the beat counter alone ends the burst;
    // rlast and the line offset bits carry no information we need.
    assign unused_inputs = ^{rlast, rd_addr[4:0]};

    // Refill FSM with registered AXI handshakes, beat packing and line return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= REFILL_IDLE;
            beat_cnt  <= '0;
            err_flag  <= 1'b0;
            araddr    <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            ret_valid <= 1'b0;
            bus_err   <= 1'b0;
            ret_data  <= '0;
        end else begin
            case (state)
                REFILL_IDLE: begin
                    if (rd_req) begin
                        araddr   <= {rd_addr[31:5], 5'b0};
                        beat_cnt <= '0;
                        err_flag <= 1'b0;
                        arvalid  <= 1'b1;
                        state    <= REFILL_AR;
                    end
                end
                REFILL_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= REFILL_R;
                    end
                end
                REFILL_R: begin
                    if (rvalid) begin
                        ret_data[int'(beat_cnt)*AXI_DW +: AXI_DW] <= rdata;
                        err_flag <= err_flag | beat_err;
                        if (beat_cnt == LAST_BEAT) begin
                            rready    <= 1'b0;
                            ret_valid <= 1'b1;
                            bus_err   <= err_flag | beat_err;
                            state     <= REFILL_DONE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                REFILL_DONE: begin
                    ret_valid <= 1'b0;
                    bus_err   <= 1'b0;
                    state     <= REFILL_IDLE;
                end
                default: begin
                    state <= REFILL_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_axi.sv
// Directed bench for icache_refill_axi with a line scoreboard.
module tb_icache_refill_axi;
    import pipeline_types::*;

    localparam int BEATS = 8;

    logic          clk;
    logic          rst_n;
    logic          rd_req;
    bus32_t        rd_addr;
    logic          ret_valid;
    logic [255:0]  ret_data;
    logic          bus_err;
    logic [3:0]    arid;
    logic [31:0]   araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;

    icache_refill_axi dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .ret_valid (ret_valid),
        .ret_data  (ret_data),
        .bus_err   (bus_err),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] line;
        logic         err;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           ar_hs = 0;
    int           ret_pulses = 0;
    int           n_done = 0;
    logic [31:0]  words[BEATS];
    logic [1:0]   resps[BEATS];
    int           gaps[BEATS];
    logic [255:0] last_line;

    // Count AR handshakes and ret_valid pulses as the DUT sees them.
    always @(posedge clk) begin
        if (rst_n && arvalid && arready) ar_hs++;
        if (rst_n && ret_valid) ret_pulses++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_req(input logic [31:0] addr);
        rd_req  = 1'b1;
        rd_addr = addr;
        tick();
        check("arvalid_after_req", arvalid, 1'b1);
        check("araddr_aligned", araddr, {addr[31:5], 5'b0});
        rd_addr = $urandom;
    endtask

    task automatic ar_phase(input int stall, input logic [31:0] addr);
        for (int i = 0; i < stall; i++) begin
            arready = 1'b0;
            tick();
            check("arvalid_stall", arvalid, 1'b1);
            check("araddr_stable", araddr, {addr[31:5], 5'b0});
            check("rready_in_ar", rready, 1'b0);
            rd_addr = $urandom;
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("arvalid_dropped", arvalid, 1'b0);
        check("rready_in_r", rready, 1'b1);
    endtask

    task automatic drive_beats(input int n, input bit push);
        exp_t e;
        e.line = '0;
        e.err  = 1'b0;
        for (int i = 0; i < BEATS; i++) begin
            e.line[i*32 +: 32] = words[i];
            e.err = e.err | (resps[i] != 2'b00);
        end
        if (push) sb.push_back(e);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                rvalid = 1'b0;
                rdata  = $urandom;
                rresp  = 2'b11;
                tick();
                check("ret_valid_early_gap", ret_valid, 1'b0);
            end
            rvalid = 1'b1;
            rdata  = words[i];
            rresp  = resps[i];
            rlast  = (i == BEATS - 1);
            tick();
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
            rdata  = $urandom;
            if (i != BEATS - 1) check("ret_valid_early_beat", ret_valid, 1'b0);
        end
    endtask

    task automatic finish_refill(input bit hold_req);
        exp_t e;
        check("ret_valid_pulse", ret_valid, 1'b1);
        check("rready_after_last", rready, 1'b0);
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL sb_empty: observed %0d entries expected >0", sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("ret_data_line", ret_data, e.line);
            check("bus_err_flag", bus_err, e.err);
            last_line = e.line;
        end
        n_done++;
        if (!hold_req) rd_req = 1'b0;
        tick();
        rd_req = 1'b0;
        check("ret_valid_single", ret_valid, 1'b0);
        check("bus_err_single", bus_err, 1'b0);
        check("ret_data_held", ret_data, last_line);
        tick();
        check("no_dup_accept", arvalid, 1'b0);
    endtask

    task automatic set_plain(input logic [31:0] seed);
        for (int i = 0; i < BEATS; i++) begin
            words[i] = seed ^ (32'h0101_0101 * (i + 1));
            resps[i] = 2'b00;
            gaps[i]  = 0;
        end
    endtask

    initial begin
        int hs0;
        rst_n   = 1'b0;
        rd_req  = 1'b0;
        rd_addr = '0;
        arready = 1'b0;
        rdata   = '0;
        rresp   = 2'b00;
        rlast   = 1'b0;
        rvalid  = 1'b0;
        tick();
        tick();
        check("rst_ret_valid", ret_valid, 1'b0);
        check("rst_bus_err", bus_err, 1'b0);
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_araddr", araddr, 32'h0);
        check("rst_ret_data", ret_data, 256'h0);
        check("const_arid", arid, 4'd0);
        check("const_arlen", arlen, 8'd7);
        check("const_arsize", arsize, 3'd2);
        check("const_arburst", arburst, 2'b01);
        rst_n = 1'b1;
        tick();

        // 1: back-to-back beats
        for (int i = 0; i < BEATS; i++) begin
            words[i] = 32'h11 * (i + 1);
            resps[i] = 2'b00;
            gaps[i]  = 0;
        end
        start_req(32'h1C00_0014);
        check("t1_araddr", araddr, 32'h1C00_0000);
        ar_phase(0, 32'h1C00_0014);
        drive_beats(BEATS, 1'b1);
        check("t1_word0", ret_data[31:0], 32'h11);
        check("t1_word7", ret_data[255:224], 32'h88);
        finish_refill(1'b0);

        // 2: arready stall
        hs0 = ar_hs;
        set_plain(32'hA5A5_0000);
        start_req(32'h2000_0060);
        ar_phase(5, 32'h2000_0060);
        check("t2_one_handshake", ar_hs - hs0, 1);
        drive_beats(BEATS, 1'b1);
        finish_refill(1'b0);

        // 3: rvalid gaps with junk on the bus
        set_plain(32'h3C3C_1234);
        gaps = '{0, 1, 0, 3, 0, 2, 1, 0};
        start_req(32'h0000_3FFF);
        ar_phase(1, 32'h0000_3FFF);
        drive_beats(BEATS, 1'b1);
        finish_refill(1'b0);

        // 4: slave error on beat 3, then a clean refill
        set_plain(32'hDEAD_0000);
        resps[3] = 2'b10;
        start_req(32'h4000_0100);
        ar_phase(0, 32'h4000_0100);
        drive_beats(BEATS, 1'b1);
        finish_refill(1'b0);
        set_plain(32'h0BAD_F00D);
        start_req(32'h4000_0120);
        ar_phase(0, 32'h4000_0120);
        drive_beats(BEATS, 1'b1);
        finish_refill(1'b0);

        // 5: reset during R after four beats
        set_plain(32'h7777_0000);
        start_req(32'h0000_1240);
        ar_phase(0, 32'h0000_1240);
        drive_beats(4, 1'b0);
        #2;
        rst_n  = 1'b0;
        rd_req = 1'b0;
        #1;
        check("t5_ret_valid", ret_valid, 1'b0);
        check("t5_arvalid", arvalid, 1'b0);
        check("t5_rready", rready, 1'b0);
        check("t5_araddr", araddr, 32'h0);
        check("t5_ret_data", ret_data, 256'h0);
        check("t5_bus_err", bus_err, 1'b0);
        tick();
        rst_n = 1'b1;
        set_plain(32'h5555_AAAA);
        start_req(32'h0000_0040);
        ar_phase(0, 32'h0000_0040);
        drive_beats(BEATS, 1'b1);
        finish_refill(1'b0);

        // 6: rd_req held through ret_valid edge, new request a cycle later
        hs0 = ar_hs;
        set_plain(32'h6666_0001);
        start_req(32'h6000_0000);
        ar_phase(2, 32'h6000_0000);
        drive_beats(BEATS, 1'b1);
        finish_refill(1'b1);
        set_plain(32'h6666_0002);
        start_req(32'h6000_0020);
        ar_phase(0, 32'h6000_0020);
        drive_beats(BEATS, 1'b1);
        finish_refill(1'b0);
        check("t6_two_handshakes", ar_hs - hs0, 2);

        check("sb_drained", sb.size(), 0);
        check("ret_pulse_count", ret_pulses, n_done);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
